// File: rtl/phy_pkg.sv
// Shared PHY definitions: character defaults, byte width and receiver state encoding.
package phy_pkg;

  localparam int PHY_BYTE_W = 8;

  localparam logic [PHY_BYTE_W-1:0] PHY_COMMA = 8'hBC;
  localparam logic [PHY_BYTE_W-1:0] PHY_IDLE  = 8'h7C;

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    LOCKED
  } rx_state_t;

  // Fill characters carry no payload and are never delivered as data.
  function automatic logic is_fill_byte(input logic [PHY_BYTE_W-1:0] b,
                                        input logic [PHY_BYTE_W-1:0] comma,
                                        input logic [PHY_BYTE_W-1:0] idle);
    return (b == comma) || (b == idle);
  endfunction

endpackage

// File: rtl/phy_rx_window.sv
// Receive shift window and bit counter for one lane; exposes the next window,
// the COMMA match on it and the byte-boundary strobe.
module phy_rx_window
  import phy_pkg::*;
#(
  parameter logic [PHY_BYTE_W-1:0] COMMA = PHY_COMMA
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  realign,
  output logic [PHY_BYTE_W-1:0] win_next,
  output logic                  comma_hit,
  output logic                  boundary
);

  logic [PHY_BYTE_W-1:0] win;
  logic [2:0]            bcnt;

  assign win_next  = {win[PHY_BYTE_W-2:0], data_in};
  assign comma_hit = (win_next == COMMA);
  assign boundary  = (bcnt == 3'd7);

  // Realign pins the byte phase so the next boundary falls 8 bits after the match.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      win  <= '0;
      bcnt <= 3'd0;
    end else begin
      win  <= win_next;
      bcnt <= realign ? 3'd0 : bcnt + 3'd1;
    end
  end

endmodule

// File: rtl/phy_rx_deserializer.sv
// Per-lane serial-to-parallel receiver: COMMA alignment, lock and byte delivery.
// Optional loss-of-sync monitor is built when PHY_RX_LOS_EN is defined.
module phy_rx_deserializer
  import phy_pkg::*;
#(
  parameter logic [PHY_BYTE_W-1:0] COMMA      = PHY_COMMA,
  parameter logic [PHY_BYTE_W-1:0] IDLE       = PHY_IDLE,
  parameter int                    LOCK_COUNT = 4,
  parameter int                    LOS_BYTES  = 16
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  input  logic                  data_in,
  output logic [PHY_BYTE_W-1:0] data_out,
  output logic                  valid_out,
  output logic                  active,
  output logic                  byte_tick
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);

  rx_state_t             state;
  logic [3:0]            lock_cnt;
  logic [PHY_BYTE_W-1:0] win_next;
  logic                  comma_hit;
  logic                  boundary;
  logic                  realign;
  logic                  los_hit;

  assign realign = (state == SEARCH) && comma_hit;

  phy_rx_window #(
    .COMMA(COMMA)
  ) u_window (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .realign  (realign),
    .win_next (win_next),
    .comma_hit(comma_hit),
    .boundary (boundary)
  );

`ifdef PHY_RX_LOS_EN
  localparam logic [7:0] LOS_LAST = 8'(LOS_BYTES - 1);

  logic [7:0] los_cnt;

  assign los_hit = (state == LOCKED) && boundary && !comma_hit && (los_cnt == LOS_LAST);

  // Counts locked byte boundaries since the most recent COMMA.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      los_cnt <= 8'd0;
    end else if (state != LOCKED) begin
      los_cnt <= 8'd0;
    end else if (boundary) begin
      los_cnt <= (comma_hit || los_hit) ? 8'd0 : los_cnt + 8'd1;
    end
  end
`else
  // Without the monitor a locked lane stays locked; LOS_BYTES is inert here.
  assign los_hit = (LOS_BYTES == 0);
`endif

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= SEARCH;
      lock_cnt  <= 4'd0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      byte_tick <= 1'b0;
    end else begin
      byte_tick <= 1'b0;
      case (state)
        SEARCH: begin
          if (comma_hit) begin
            lock_cnt <= 4'd1;
            if (LOCK_COUNT == 1) begin
              state  <= LOCKED;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (comma_hit) begin
              lock_cnt <= lock_cnt + 4'd1;
              if (lock_cnt == LOCK_LAST) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              state    <= SEARCH;
              lock_cnt <= 4'd0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            byte_tick <= 1'b1;
            if (los_hit) begin
              state     <= SEARCH;
              lock_cnt  <= 4'd0;
              active    <= 1'b0;
              valid_out <= 1'b0;
            end else if (is_fill_byte(win_next, COMMA, IDLE)) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= win_next;
              valid_out <= 1'b1;
            end
          end
        end
        default: begin
          state    <= SEARCH;
          lock_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/phy_rx_deserializer.md
# phy_rx_deserializer

Serial-to-parallel receiver for one PHY lane. Runs on `clk_32f`, takes the 1-bit stream produced by the lane serializer, finds byte alignment from COMMA characters, locks after a run of consecutive COMMAs, and then delivers 8-bit data bytes with a valid flag at one byte per 8 clocks. One instance per lane. Its outputs feed the lane demux on the receive side of `phy`.

## Interface

Parameters:
- `COMMA`, 8'hBC: alignment character.
- `IDLE`, 8'h7C: fill character sent while the transmitter has no valid data.
- `LOCK_COUNT`, 4: consecutive aligned COMMAs required to lock (range 1..15).
- `LOS_BYTES`, 16: bytes allowed without a COMMA before loss of sync (used only with `PHY_RX_LOS_EN`; range 2..255).

Ports:
- `clk_32f` input, 1 bit: bit clock; the only clock. Everything is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `data_in` input, 1 bit: serial stream, MSB of each byte first.
- `data_out` output, 8 bits: last delivered data byte.
- `valid_out` output, 1 bit: `data_out` holds a data byte (not COMMA or IDLE).
- `active` output, 1 bit: lane is locked.
- `byte_tick` output, 1 bit: one-cycle pulse on each clock where a new byte decision is registered.

## Operation

- Shift register `win[7:0]`: `win <= {win[6:0], data_in}` every cycle, including during lock.
- 3-bit bit counter `bcnt`. A byte boundary is the cycle in which `bcnt == 7`; that cycle's updated `win` is the received byte.
- Reset values: state SEARCH, `win` 0, `bcnt` 0, lock counter 0, `data_out` 8'h00, `valid_out` 0, `active` 0, `byte_tick` 0.
- **SEARCH**
  - Each cycle, compare the updated window `{win[6:0], data_in}` with `COMMA`.
  - On a match: `bcnt <= 0` (alignment fixed here), lock counter `<= 1`, go to ALIGN. If `LOCK_COUNT == 1`, go directly to LOCKED.
- **ALIGN**
  - At each boundary, a byte equal to `COMMA` increments the lock counter. When the counter reaches `LOCK_COUNT`, go to LOCKED and set `active <= 1`.
  - Any other byte at a boundary returns to SEARCH and clears the counter.
- **LOCKED**
  - At each boundary, `byte_tick <= 1`.
  - Byte is `COMMA` or `IDLE`: `valid_out <= 0`, `data_out` holds its previous value.
  - Any other byte: `data_out <= byte`, `valid_out <= 1`.
  - Between boundaries, `valid_out` and `data_out` hold.
- `bcnt` wraps 7→0 in every state. In SEARCH it is overridden on a COMMA match.
- Reset asserted mid-byte or mid-lock returns everything to reset values on the next edge. Any partial byte is discarded and no `byte_tick` is produced.

## Timing

- Latency: the last bit of a byte is sampled on edge N; `data_out`, `valid_out` and `byte_tick` update on the same edge N (registered from the combinational next-window). They are visible from N until N+8.
- Lock time from the first COMMA's last bit: `(LOCK_COUNT-1)*8` clocks. `active` rises on the edge that samples the last bit of the LOCK_COUNT-th COMMA.
- `valid_out` is level-held for exactly one byte period, i.e. 8 `clk_32f` cycles, equal to one `clk_4f` period. Back-to-back data bytes keep `valid_out` high continuously.
- There is no backpressure: the consumer must sample on `byte_tick`.

## Configuration

- `PHY_RX_LOS_EN` defined:
  - In LOCKED, a byte counter counts boundaries since the last `COMMA`.
  - When it reaches `LOS_BYTES`, on that boundary: `active <= 0`, `valid_out <= 0`, state SEARCH, lock counter 0, and the byte is not delivered.
  - A COMMA byte clears the counter.
- `PHY_RX_LOS_EN` undefined: once LOCKED, the block stays locked until `reset`. No LOS counter logic is present.

## Structure

- Shared package `phy_pkg`:
  - Default values for `COMMA` and `IDLE`.
  - State encoding `rx_state_t` {SEARCH, ALIGN, LOCKED}.
  - Width constant `PHY_BYTE_W = 8`.
- One sub-module, `phy_rx_window`: holds the shift register and bit counter, and produces the next-window value, `comma_hit` and `boundary`. The FSM and output registers live in `phy_rx_deserializer`.

## Test plan

- Reset held 4 cycles, then the stream BC,BC,BC,BC,55,A3 is sent MSB-first:
  - `active` rises on the last bit of the 4th BC.
  - `data_out` = 8'h55 with `valid_out` = 1 for 8 cycles, then 8'hA3.
- Stream BC,BC,7C,BC,BC,BC,BC,12:
  - The 7C returns the block to SEARCH.
  - Lock is reached only after the following four BCs.
  - Then `data_out` = 8'h12.
- 3 junk bits, then BC×4, 7C, 7C, 99:
  - Alignment is found despite the offset.
  - `valid_out` stays 0 during the 7Cs and `data_out` stays 8'h00.
  - Then 8'h99 is delivered.
- Locked, then `reset` pulsed in the middle of byte 8'h5A: all outputs return to 0 on the next edge and no 5A is delivered.
- `PHY_RX_LOS_EN` with `LOS_BYTES` = 16, 20 non-COMMA data bytes after lock:
  - Bytes 1–15 are delivered.
  - On the 16th boundary `active` drops to 0 and `valid_out` to 0.
- `LOCK_COUNT` = 1: the single BC sets `active` on its last bit, and the next byte 8'hF0 is delivered.
